// File: rtl/sfx_sweep_player.sv
// Square-wave sound-effect generator: a trigger starts a tone whose half-period
// steps up or down over a programmable number of fixed-length steps, then the
// channel stops and pulses done for one cycle.
module sfx_sweep_player #(
    parameter int CNT_W   = 17,
    parameter int DUR_W   = 24,
    parameter int STEPS_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               sweep_down,
    input  logic [CNT_W-1:0]   start_half,
    input  logic [CNT_W-1:0]   step_delta,
    input  logic [STEPS_W-1:0] num_steps,
    input  logic [DUR_W-1:0]   step_len,
    input  logic               mute,
    output logic               sound_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [DUR_W-1:0]   DUR_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0]   DUR_ONE    = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [STEPS_W-1:0] STEPS_ZERO = {STEPS_W{1'b0}};
    localparam logic [STEPS_W-1:0] STEPS_ONE  = {{(STEPS_W-1){1'b0}}, 1'b1};

    state_t             r_state,      w_next_state;
    logic               r_sweep_down, w_next_sweep_down;
    logic [CNT_W-1:0]   r_delta,      w_next_delta;
    logic [STEPS_W-1:0] r_num_steps,  w_next_num_steps;
    logic [DUR_W-1:0]   r_step_len,   w_next_step_len;
    logic [CNT_W-1:0]   r_half,       w_next_half;
    logic [CNT_W-1:0]   r_tone_cnt,   w_next_tone_cnt;
    logic [DUR_W-1:0]   r_dur_cnt,    w_next_dur_cnt;
    logic [STEPS_W-1:0] r_step_idx,   w_next_step_idx;
    logic               r_phase,      w_next_phase;
    logic               r_sound,      w_next_sound;
    logic               r_busy;
    logic               r_done,       w_next_done;

    logic               w_step_end;
    logic               w_last_step;
    logic               w_tone_wrap;
    logic [CNT_W-1:0]   w_half_rise;
    logic [CNT_W:0]     w_half_sum;
    logic [CNT_W-1:0]   w_half_fall;

    assign w_step_end  = (r_dur_cnt == (r_step_len - DUR_ONE));
    assign w_last_step = (r_step_idx == (r_num_steps - STEPS_ONE));
    assign w_tone_wrap = (r_tone_cnt == (r_half - CNT_ONE));
    // Rising sweep shrinks the half-period but never below one cycle.
    assign w_half_rise = (r_half > r_delta) ? (r_half - r_delta) : CNT_ONE;
    // Falling sweep adds one bit of headroom so overflow clamps to full scale.
    assign w_half_sum  = {1'b0, r_half} + {1'b0, r_delta};
    assign w_half_fall = w_half_sum[CNT_W] ? CNT_MAX : w_half_sum[CNT_W-1:0];

    // Next-state and next-output logic; a trigger always wins over step/end events.
    always_comb begin
        w_next_state      = r_state;
        w_next_sweep_down = r_sweep_down;
        w_next_delta      = r_delta;
        w_next_num_steps  = r_num_steps;
        w_next_step_len   = r_step_len;
        w_next_half       = r_half;
        w_next_tone_cnt   = r_tone_cnt;
        w_next_dur_cnt    = r_dur_cnt;
        w_next_step_idx   = r_step_idx;
        w_next_phase      = r_phase;
        w_next_done       = 1'b0;
        if (trigger) begin
            w_next_state      = S_PLAY;
            w_next_sweep_down = sweep_down;
            w_next_delta      = step_delta;
            w_next_num_steps  = (num_steps == STEPS_ZERO) ? STEPS_ONE : num_steps;
            w_next_step_len   = (step_len == DUR_ZERO) ? DUR_ONE : step_len;
            w_next_half       = (start_half == CNT_ZERO) ? CNT_ONE : start_half;
            w_next_tone_cnt   = CNT_ZERO;
            w_next_dur_cnt    = DUR_ZERO;
            w_next_step_idx   = STEPS_ZERO;
            w_next_phase      = 1'b1;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_step_end) begin
                        w_next_tone_cnt = CNT_ZERO;
                        w_next_dur_cnt  = DUR_ZERO;
                        if (w_last_step) begin
                            w_next_state    = S_IDLE;
                            w_next_step_idx = STEPS_ZERO;
                            w_next_phase    = 1'b0;
                            w_next_done     = 1'b1;
                        end else begin
                            w_next_step_idx = r_step_idx + STEPS_ONE;
                            w_next_phase    = 1'b1;
                            w_next_half     = r_sweep_down ? w_half_fall : w_half_rise;
                        end
                    end else begin
                        w_next_dur_cnt = r_dur_cnt + DUR_ONE;
                        if (w_tone_wrap) begin
                            w_next_tone_cnt = CNT_ZERO;
                            w_next_phase    = ~r_phase;
                        end else begin
                            w_next_tone_cnt = r_tone_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_next_state    = S_IDLE;
                    w_next_tone_cnt = CNT_ZERO;
                    w_next_dur_cnt  = DUR_ZERO;
                    w_next_step_idx = STEPS_ZERO;
                    w_next_phase    = 1'b0;
                end
            endcase
        end
        w_next_sound = w_next_phase & ~mute & (w_next_state == S_PLAY);
    end

    // State, configuration, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sweep_down <= 1'b0;
            r_delta      <= CNT_ZERO;
            r_num_steps  <= STEPS_ZERO;
            r_step_len   <= DUR_ZERO;
            r_half       <= CNT_ZERO;
            r_tone_cnt   <= CNT_ZERO;
            r_dur_cnt    <= DUR_ZERO;
            r_step_idx   <= STEPS_ZERO;
            r_phase      <= 1'b0;
            r_sound      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sweep_down <= w_next_sweep_down;
            r_delta      <= w_next_delta;
            r_num_steps  <= w_next_num_steps;
            r_step_len   <= w_next_step_len;
            r_half       <= w_next_half;
            r_tone_cnt   <= w_next_tone_cnt;
            r_dur_cnt    <= w_next_dur_cnt;
            r_step_idx   <= w_next_step_idx;
            r_phase      <= w_next_phase;
            r_sound      <= w_next_sound;
            r_busy       <= (w_next_state == S_PLAY);
            r_done       <= w_next_done;
        end
    end

    assign sound_out = r_sound;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
